// File: rtl/mem_lsu.sv
// Load/store unit: accepts one load or store, checks it, runs a single
// memory cycle on the data-memory port and returns data/status over a
// valid/ready response handshake. One transaction in flight at a time.
module mem_lsu #(
    parameter logic [31:0] MEM_BYTES = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_rw,
    output logic [2:0]  mem_func,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, LOAD_WAIT, RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    state_t      state;
    logic        is_store;
    logic [31:0] ea;
    logic        f_illegal;
    logic        f_misalign;
    logic        f_range;

    // Effective address and fault classification of the presented request
    always_comb begin
        ea         = req_base + req_offset;
        f_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_store && req_funct3[2]);
        f_misalign = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        f_range    = (ea >= MEM_BYTES);
    end

    // Control FSM; the mem_* registers double as the latched request so a
    // faulting request leaves the memory port untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_store   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            mem_rw     <= 1'b0;
            mem_func   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (f_illegal || f_misalign || f_range) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            if (f_illegal)       resp_err <= ERR_ILLEGAL;
                            else if (f_misalign) resp_err <= ERR_MISALGN;
                            else                 resp_err <= ERR_RANGE;
                            state <= RESP;
                        end else begin
                            mem_addr  <= ea;
                            mem_func  <= req_funct3;
                            mem_wdata <= req_wdata;
                            mem_rw    <= req_store;
                            is_store  <= req_store;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    mem_rw <= 1'b0;
                    if (is_store) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_OK;
                        state      <= RESP;
                    end else begin
                        state <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= mem_rdata;
                    resp_err   <= ERR_OK;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a byte-addressed memory model on the
// data-memory port.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_base = '0;
    logic [31:0] req_offset = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_rw;
    logic [2:0]  mem_func;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    mem_lsu #(.MEM_BYTES(32'h0040_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rw(mem_rw), .mem_func(mem_func), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte lanes, little-endian, registered read with extension
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rdb(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] w;
        w = {rdb(a + 32'd3), rdb(a + 32'd2), rdb(a + 32'd1), rdb(a)};
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr] = mem_wdata[7:0];
            if (mem_func[1:0] != 2'b00) mem[mem_addr + 32'd1] = mem_wdata[15:8];
            if (mem_func[1:0] == 2'b10) begin
                mem[mem_addr + 32'd2] = mem_wdata[23:16];
                mem[mem_addr + 32'd3] = mem_wdata[31:24];
            end
        end else begin
            mem_rdata <= mem_read(mem_addr, mem_func);
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int unsigned lat;
        int unsigned wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned wr_cnt = 0;
    bit          seen = 1'b0;
    bit          hs = 1'b0;
    time         acc_time = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per response and checks the memory port
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rw) begin
                if (sb.size() == 0) chk("unexpected_mem_rw", 32'd1, 32'd0);
                else begin
                    wr_cnt++;
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_wdata", mem_wdata, sb[0].wdata);
                    chk("mem_func", {29'd0, mem_func}, {29'd0, sb[0].f3});
                end
            end
            if (resp_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                    else begin
                        cur  = sb.pop_front();
                        seen = 1'b1;
                        chk("resp_rdata", resp_rdata, cur.rdata);
                        chk("resp_err", {30'd0, resp_err}, {30'd0, cur.err});
                        chk("latency", ($time - acc_time + 5) / 10, cur.lat);
                        chk("store_cycles", wr_cnt, cur.wr);
                        wr_cnt = 0;
                    end
                end else begin
                    chk("stable_rdata", resp_rdata, cur.rdata);
                    chk("stable_err", {30'd0, resp_err}, {30'd0, cur.err});
                end
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                if (resp_ready) begin
                    seen = 1'b0;
                    hs   = 1'b1;
                end
            end else if (hs) begin
                chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
                hs = 1'b0;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] wd);
        int unsigned n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        req_store  = st;
        req_funct3 = f3;
        req_base   = b;
        req_offset = o;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        acc_time = $time;
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] b,
                          input logic [31:0] o, input logic [31:0] wd,
                          input logic [31:0] e_rd, input logic [1:0] e_err,
                          input int unsigned e_lat, input logic [31:0] e_addr);
        exp_t e;
        e.rdata = e_rd;
        e.err   = e_err;
        e.lat   = e_lat;
        e.wr    = (st && e_err == 2'b00) ? 1 : 0;
        e.addr  = e_addr;
        e.wdata = wd;
        e.f3    = f3;
        sb.push_back(e);
        issue(st, f3, b, o, wd);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || resp_valid) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {30'd0, resp_err}, 32'd0);
        chk({tag, "_mem_rw"}, {31'd0, mem_rw}, 32'd0);
        chk({tag, "_mem_func"}, {29'd0, mem_func}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #12 chk_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;

        // word store then load back; halfword sign/zero extension
        do_req(1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 32'h0, 2'b00, 2, 32'h104);
        do_req(0, 3'b010, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 2'b00, 3, 32'h104);
        do_req(0, 3'b001, 32'h100, 32'h6, 32'h0, 32'hFFFFDEAD, 2'b00, 3, 32'h106);
        do_req(0, 3'b101, 32'h100, 32'h6, 32'h0, 32'h0000DEAD, 2'b00, 3, 32'h106);

        // byte store into top lane of a known word
        do_req(1, 3'b010, 32'h100, 32'h0, 32'h11223344, 32'h0, 2'b00, 2, 32'h100);
        do_req(1, 3'b000, 32'h100, 32'h3, 32'hFFFFFF80, 32'h0, 2'b00, 2, 32'h103);
        do_req(0, 3'b000, 32'h100, 32'h3, 32'h0, 32'hFFFFFF80, 2'b00, 3, 32'h103);
        do_req(0, 3'b100, 32'h100, 32'h3, 32'h0, 32'h00000080, 2'b00, 3, 32'h103);
        do_req(0, 3'b010, 32'h100, 32'h0, 32'h0, 32'h80223344, 2'b00, 3, 32'h100);

        // misaligned accesses
        do_req(1, 3'b010, 32'h200, 32'h0, 32'hA5A5A5A5, 32'h0, 2'b00, 2, 32'h200);
        do_req(0, 3'b010, 32'h100, 32'h2, 32'h0, 32'h0, 2'b01, 1, 32'h0);
        do_req(0, 3'b001, 32'h100, 32'h1, 32'h0, 32'h0, 2'b01, 1, 32'h0);
        do_req(1, 3'b001, 32'h200, 32'h3, 32'h00001234, 32'h0, 2'b01, 1, 32'h0);
        do_req(0, 3'b010, 32'h200, 32'h0, 32'h0, 32'hA5A5A5A5, 2'b00, 3, 32'h200);

        // range, illegal and fault priority
        do_req(0, 3'b010, 32'h00400000, 32'h0, 32'h0, 32'h0, 2'b10, 1, 32'h0);
        do_req(0, 3'b010, 32'h003FFFF0, 32'hC, 32'h0, 32'h0, 2'b00, 3, 32'h003FFFFC);
        do_req(0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 2'b11, 1, 32'h0);
        do_req(1, 3'b100, 32'h100, 32'h0, 32'h55, 32'h0, 2'b11, 1, 32'h0);
        do_req(1, 3'b111, 32'h00400001, 32'h0, 32'h55, 32'h0, 2'b11, 1, 32'h0);
        do_req(0, 3'b010, 32'h00400002, 32'h0, 32'h0, 32'h0, 2'b01, 1, 32'h0);

        // address wrap and negative offset
        do_req(1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0BADF00D, 32'h0, 2'b00, 2, 32'h4);
        do_req(0, 3'b010, 32'h108, 32'hFFFFFFFC, 32'h0, 32'hDEADBEEF, 2'b00, 3, 32'h104);
        do_req(0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0BADF00D, 2'b00, 3, 32'h4);
        drain();

        // response back-pressure
        resp_ready = 1'b0;
        do_req(0, 3'b010, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 2'b00, 3, 32'h104);
        begin
            int unsigned n = 0;
            while (!resp_valid && n < 20) begin
                @(posedge clk);
                n++;
            end
            if (!resp_valid) chk("stall_resp_timeout", 32'd0, 32'd1);
        end
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

        // reset in the middle of a store's ACCESS cycle
        do_req(1, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 32'h0, 2'b00, 2, 32'h300);
        drain();
        issue(1, 3'b010, 32'h300, 32'h0, 32'h12345678);
        #1 rst_n = 1'b0;
        #1 chk("abort_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        do_req(0, 3'b010, 32'h300, 32'h0, 32'h0, 32'hCAFEF00D, 2'b00, 3, 32'h300);
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
